reg_op_seq: RTL and testbench

Multi-cycle operation sequencer sitting directly upstream of the 8×8 register file (`reg_mod`). It accepts one 16-bit instruction at a time over a valid/ready handshake and reads two operands through the file's combinational read ports. It computes an 8-bit ALU result and writes it back through the file's single write port. Zero and carry flags are kept, and a one-cycle `done` pulse marks each instruction's retirement.

---
 rtl/reg_op_pkg.sv | 43 ++++
 rtl/reg_op_seq_alu8.sv | 73 +++++++
 rtl/reg_op_seq.sv | 155 +++++++++++++++
 tb/tb_reg_op_seq.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_op_pkg.sv
// Shared definitions for the register-file operation sequencer.
//
// Contents:
//   OP_*        4-bit opcodes understood by the ALU (10..15 are illegal)
//   state_t     2-bit sequencer state encoding
//   *_MSB/*_LSB bit positions of the instruction fields
//   opIsIllegal helper that flags opcodes outside the defined set
package reg_op_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_MOV = 4'd7;
    localparam logic [3:0] OP_LDI = 4'd8;
    localparam logic [3:0] OP_NOP = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_EXEC  = 2'b10,
        ST_WRITE = 2'b11
    } state_t;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RS1_MSB = 8;
    localparam int RS1_LSB = 6;
    localparam int RS2_MSB = 5;
    localparam int RS2_LSB = 3;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    function automatic logic opIsIllegal(input logic [3:0] op);
        return (op > OP_NOP);
    endfunction

endpackage

// File: rtl/reg_op_seq_alu8.sv
// alu8: purely combinational ALU used by the sequencer's EXEC step.
//
// Ports:
//   op_i        opcode
//   a_i, b_i    operands (rs1 / rs2 values)
//   imm8_i      immediate for LDI
//   result_o    computed result
//   c_out_o     carry / borrow / last shifted-out bit
//   z_out_o     result is zero
//   writes_o    op writes its result back to the register file
//   flags_upd_o op updates the zero and carry flags
//   illegal_o   opcode is outside the defined set
module alu8 #(
    parameter int DW = 8
) (
    input  logic [3:0]    op_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic [7:0]    imm8_i,
    output logic [DW-1:0] result_o,
    output logic          c_out_o,
    output logic          z_out_o,
    output logic          writes_o,
    output logic          flags_upd_o,
    output logic          illegal_o
);
    import reg_op_pkg::*;

    localparam int SW = $clog2(DW);

    logic [SW-1:0] shamt;
    logic [DW:0]   sum;
    logic [DW:0]   diff;
    logic [DW:0]   shl;
    logic [DW:0]   shr;

    // The extra bit on each intermediate catches the carry, the borrow, or
    // the last bit pushed out by a shift (left: top bit, right: bottom bit).
    // A zero shift amount leaves that extra bit at 0, which is the required carry.
    assign shamt = b_i[SW-1:0];
    assign sum   = {1'b0, a_i} + {1'b0, b_i};
    assign diff  = {1'b0, a_i} - {1'b0, b_i};
    assign shl   = {1'b0, a_i} << shamt;
    assign shr   = {a_i, 1'b0} >> shamt;

    // Opcode decode: result, carry and the write / flag / illegal qualifiers.
    always_comb begin
        result_o    = '0;
        c_out_o     = 1'b0;
        writes_o    = 1'b1;
        flags_upd_o = 1'b0;
        illegal_o   = 1'b0;
        case (op_i)
            OP_ADD: begin result_o = sum[DW-1:0];  c_out_o = sum[DW];  flags_upd_o = 1'b1; end
            OP_SUB: begin result_o = diff[DW-1:0]; c_out_o = diff[DW]; flags_upd_o = 1'b1; end
            OP_AND: begin result_o = a_i & b_i; flags_upd_o = 1'b1; end
            OP_OR:  begin result_o = a_i | b_i; flags_upd_o = 1'b1; end
            OP_XOR: begin result_o = a_i ^ b_i; flags_upd_o = 1'b1; end
            OP_SHL: begin result_o = shl[DW-1:0];  c_out_o = shl[DW];  flags_upd_o = 1'b1; end
            OP_SHR: begin result_o = shr[DW:1];    c_out_o = shr[0];   flags_upd_o = 1'b1; end
            OP_MOV: result_o = a_i;
            OP_LDI: result_o = DW'(imm8_i);
            OP_NOP: writes_o = 1'b0;
            default: begin
                writes_o  = 1'b0;
                illegal_o = opIsIllegal(op_i);
            end
        endcase
    end

    assign z_out_o = (result_o == '0);

endmodule

// File: rtl/reg_op_seq.sv
// reg_op_seq: four-step (IDLE/READ/EXEC/WRITE) instruction sequencer that
// drives an 8x8 register file with combinational read ports.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   instr_valid / instr_ready instruction handshake, instr is the 16-bit word
//   read_add1/2, read_data1/2 operand read ports of the register file
//   write_en/add/data         single write port of the register file
//   done                      one-cycle retirement pulse (WRITE cycle)
//   err                       sticky illegal-opcode flag
//   flag_z, flag_c            zero / carry from the last flag-updating op
module reg_op_seq #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [15:0]   instr,
    output logic [AW-1:0] read_add1,
    output logic [AW-1:0] read_add2,
    input  logic [DW-1:0] read_data1,
    input  logic [DW-1:0] read_data2,
    output logic          write_en,
    output logic [AW-1:0] write_add,
    output logic [DW-1:0] write_data,
    output logic          done,
    output logic          err,
    output logic          flag_z,
    output logic          flag_c
);
    import reg_op_pkg::*;

    state_t        state_q, state_d;
    logic [3:0]    opc_q;
    logic [AW-1:0] rd_q;
    logic [7:0]    imm_q;
    logic [AW-1:0] readAdd1_q, readAdd2_q;
    logic [DW-1:0] opA_q, opB_q;
    logic          writeEn_q;
    logic [AW-1:0] writeAdd_q;
    logic [DW-1:0] writeData_q;
    logic          done_q, err_q, flagZ_q, flagC_q;

    logic          accept, capture, execute, retire;
    logic [DW-1:0] aluResult;
    logic          aluC, aluZ, aluWrites, aluFlagsUpd, aluIllegal;

    alu8 #(.DW(DW)) uAlu (
        .op_i        (opc_q),
        .a_i         (opA_q),
        .b_i         (opB_q),
        .imm8_i      (imm_q),
        .result_o    (aluResult),
        .c_out_o     (aluC),
        .z_out_o     (aluZ),
        .writes_o    (aluWrites),
        .flags_upd_o (aluFlagsUpd),
        .illegal_o   (aluIllegal)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: every instruction walks READ -> EXEC -> WRITE, one cycle each.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (instr_valid) state_d = ST_READ;
            ST_READ:  state_d = ST_EXEC;
            ST_EXEC:  state_d = ST_WRITE;
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Per-state strobes; ready is masked by rst so nothing is offered during reset.
    always_comb begin
        instr_ready = (state_q == ST_IDLE) && !rst;
        accept      = instr_ready && instr_valid;
        capture     = (state_q == ST_READ);
        execute     = (state_q == ST_EXEC);
        retire      = (state_q == ST_WRITE);
    end

    // Datapath. Read addresses are loaded straight from the incoming word so
    // they are already valid in READ, and are otherwise held. Write-port
    // outputs are loaded at the end of EXEC so they appear exactly in WRITE.
    // Reset clears everything, which discards any half-finished instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opc_q       <= '0;
            rd_q        <= '0;
            imm_q       <= '0;
            readAdd1_q  <= '0;
            readAdd2_q  <= '0;
            opA_q       <= '0;
            opB_q       <= '0;
            writeEn_q   <= 1'b0;
            writeAdd_q  <= '0;
            writeData_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            flagZ_q     <= 1'b0;
            flagC_q     <= 1'b0;
        end else begin
            if (accept) begin
                opc_q      <= instr[OPC_MSB:OPC_LSB];
                rd_q       <= AW'(instr[RD_MSB:RD_LSB]);
                imm_q      <= instr[IMM_MSB:IMM_LSB];
                readAdd1_q <= AW'(instr[RS1_MSB:RS1_LSB]);
                readAdd2_q <= AW'(instr[RS2_MSB:RS2_LSB]);
            end
            if (capture) begin
                opA_q <= read_data1;
                opB_q <= read_data2;
            end
            if (execute) begin
                writeEn_q   <= aluWrites;
                writeAdd_q  <= rd_q;
                writeData_q <= aluResult;
                done_q      <= 1'b1;
                if (aluFlagsUpd) begin
                    flagZ_q <= aluZ;
                    flagC_q <= aluC;
                end
                if (aluIllegal) begin
                    err_q <= 1'b1;
                end
            end
            if (retire) begin
                writeEn_q <= 1'b0;
                done_q    <= 1'b0;
            end
        end
    end

    assign read_add1  = readAdd1_q;
    assign read_add2  = readAdd2_q;
    assign write_en   = writeEn_q && !rst;
    assign write_add  = writeAdd_q;
    assign write_data = writeData_q;
    assign done       = done_q;
    assign err        = err_q;
    assign flag_z     = flagZ_q;
    assign flag_c     = flagC_q;

endmodule

// File: tb/tb_reg_op_seq.sv
// Testbench for reg_op_seq: a behavioural 8x8 register file is attached to
// the sequencer, and each instruction's write-back, flags and error status
// are compared with an arithmetic reference model of the instruction set.
module tb_reg_op_seq;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [2:0]  read_add1, read_add2, write_add;
    logic [7:0]  read_data1, read_data2, write_data;
    logic        write_en, done, err, flag_z, flag_c;

    logic [7:0]  rf [8];

    int checksPassed = 0;
    int checksTotal  = 0;

    // Reference model state
    logic [7:0] mRf [8];
    logic       mZ, mC, mErr;
    logic       expWe;
    logic [2:0] expAdd;
    logic [7:0] expData;

    // Observations of the last instruction
    logic       obsWe, obsDone, obsEarly, obsReadyLow, obsReady4;
    logic       obsZ, obsC, obsErr, timeoutHit;
    logic [2:0] obsAdd;
    logic [7:0] obsData;
    time        writeTime;

    reg_op_seq #(.DW(8), .AW(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .read_add1   (read_add1),
        .read_add2   (read_add2),
        .read_data1  (read_data1),
        .read_data2  (read_data2),
        .write_en    (write_en),
        .write_add   (write_add),
        .write_data  (write_data),
        .done        (done),
        .err         (err),
        .flag_z      (flag_z),
        .flag_c      (flag_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: combinational reads, write on the rising edge
    assign read_data1 = rf[read_add1];
    assign read_data2 = rf[read_add2];
    always @(posedge clk) begin
        if (write_en) rf[write_add] <= write_data;
    end

    function automatic logic [15:0] mkInstr(input int op, input int rd, input int rs1, input int rs2);
        logic [15:0] w;
        w = '0;
        w[15:12] = 4'(op);
        w[11:9]  = 3'(rd);
        w[8:6]   = 3'(rs1);
        w[5:3]   = 3'(rs2);
        return w;
    endfunction

    function automatic logic [15:0] mkLdi(input int rd, input int imm);
        logic [15:0] w;
        w = '0;
        w[15:12] = 4'd8;
        w[11:9]  = 3'(rd);
        w[7:0]   = 8'(imm);
        return w;
    endfunction

    // Instruction-set model written from the opcode rules with integer arithmetic
    function automatic void modelExec(input logic [15:0] ins);
        int  op, rd, a, b, s, r;
        bit  c, wr, upd;
        op  = int'(ins[15:12]);
        rd  = int'(ins[11:9]);
        a   = int'(mRf[ins[8:6]]);
        b   = int'(mRf[ins[5:3]]);
        s   = b % 8;
        r   = 0;
        c   = 0;
        wr  = 1;
        upd = 1;
        case (op)
            0: begin r = (a + b) % 256; c = (a + b) > 255; end
            1: begin r = (a - b + 256) % 256; c = (a < b); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin r = (a * (1 << s)) % 256; c = (s != 0) ? ((a >> (8 - s)) & 1) == 1 : 1'b0; end
            6: begin r = a / (1 << s); c = (s != 0) ? ((a >> (s - 1)) & 1) == 1 : 1'b0; end
            7: begin r = a; upd = 0; end
            8: begin r = int'(ins[7:0]); upd = 0; end
            9: begin wr = 0; upd = 0; end
            default: begin wr = 0; upd = 0; mErr = 1'b1; end
        endcase
        expWe   = wr;
        expAdd  = 3'(rd);
        expData = 8'(r);
        if (wr)  mRf[rd] = 8'(r);
        if (upd) begin mZ = (r == 0); mC = c; end
    endfunction

    function automatic void modelReset();
        mZ   = 1'b0;
        mC   = 1'b0;
        mErr = 1'b0;
    endfunction

    // Issue one instruction (called at a falling edge) and record cycles 1..4.
    // With hold set, instr_valid stays high so the next call follows back-to-back.
    task automatic applyStimulus(input logic [15:0] ins, input bit hold);
        int waitCnt;
        waitCnt     = 0;
        timeoutHit  = 1'b0;
        instr_valid = 1'b1;
        instr       = ins;
        while (!instr_ready && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!instr_ready) begin
            timeoutHit  = 1'b1;
            instr_valid = 1'b0;
            return;
        end
        @(posedge clk);
        obsEarly    = 1'b0;
        obsReadyLow = 1'b1;
        for (int cyc = 1; cyc <= 3; cyc++) begin
            @(negedge clk);
            if (cyc == 1 && !hold) instr_valid = 1'b0;
            if (instr_ready) obsReadyLow = 1'b0;
            if (cyc < 3 && (write_en || done)) obsEarly = 1'b1;
            if (cyc == 3) begin
                obsWe     = write_en;
                obsDone   = done;
                obsAdd    = write_add;
                obsData   = write_data;
                writeTime = $time;
            end
        end
        @(negedge clk);
        obsReady4 = instr_ready;
        obsZ      = flag_z;
        obsC      = flag_c;
        obsErr    = err;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        for (int i = 0; i < 8; i++) begin rf[i] = 8'h00; mRf[i] = 8'h00; end
        modelReset();
        @(posedge clk);
        @(negedge clk);
        checksTotal++;
        if (instr_ready !== 1'b0) $display("[TB] FAIL reset_ready_low: got %b want 0", instr_ready);
        else checksPassed++;
        checksTotal++;
        if ({write_en, done, err, flag_z, flag_c} !== 5'b0)
            $display("[TB] FAIL reset_flags: got %b want 00000", {write_en, done, err, flag_z, flag_c});
        else checksPassed++;
        checksTotal++;
        if ({read_add1, read_add2, write_add, write_data} !== 17'h0)
            $display("[TB] FAIL reset_addr_data: got %h want 0", {read_add1, read_add2, write_add, write_data});
        else checksPassed++;
        rst = 1'b0;
        #1;
        checksTotal++;
        if (instr_ready !== 1'b1) $display("[TB] FAIL reset_ready_after: got %b want 1", instr_ready);
        else checksPassed++;
    endtask

    task automatic test_ldi_add();
        time t1;
        applyStimulus(mkLdi(1, 8'h7F), 1'b1);
        modelExec(mkLdi(1, 8'h7F));
        t1 = writeTime;
        checksTotal++;
        if ({obsWe, obsDone, obsAdd, obsData} !== {1'b1, 1'b1, 3'd1, 8'h7F})
            $display("[TB] FAIL ldi_r1: got we=%b done=%b add=%0d data=%h want 1 1 1 7f", obsWe, obsDone, obsAdd, obsData);
        else checksPassed++;
        applyStimulus(mkLdi(2, 8'h81), 1'b0);
        modelExec(mkLdi(2, 8'h81));
        checksTotal++;
        if ({obsWe, obsDone, obsAdd, obsData} !== {1'b1, 1'b1, 3'd2, 8'h81})
            $display("[TB] FAIL ldi_r2: got we=%b done=%b add=%0d data=%h want 1 1 2 81", obsWe, obsDone, obsAdd, obsData);
        else checksPassed++;
        checksTotal++;
        if (writeTime - t1 !== 40) $display("[TB] FAIL ldi_spacing: got %0t want 40", writeTime - t1);
        else checksPassed++;
        applyStimulus(mkInstr(0, 3, 1, 2), 1'b0);
        modelExec(mkInstr(0, 3, 1, 2));
        checksTotal++;
        if ({obsWe, obsAdd, obsData, obsZ, obsC} !== {1'b1, 3'd3, 8'h00, 1'b1, 1'b1})
            $display("[TB] FAIL add_wrap: got we=%b add=%0d data=%h z=%b c=%b want 1 3 00 1 1", obsWe, obsAdd, obsData, obsZ, obsC);
        else checksPassed++;
        checksTotal++;
        if (rf[3] !== 8'h00) $display("[TB] FAIL add_rf3: got %h want 00", rf[3]);
        else checksPassed++;
    endtask

    task automatic test_sub();
        applyStimulus(mkLdi(1, 8'h05), 1'b0); modelExec(mkLdi(1, 8'h05));
        applyStimulus(mkLdi(2, 8'h07), 1'b0); modelExec(mkLdi(2, 8'h07));
        applyStimulus(mkInstr(1, 4, 1, 2), 1'b0);
        modelExec(mkInstr(1, 4, 1, 2));
        checksTotal++;
        if ({obsWe, obsAdd, obsData, obsZ, obsC} !== {1'b1, 3'd4, 8'hFE, 1'b0, 1'b1})
            $display("[TB] FAIL sub_borrow: got we=%b add=%0d data=%h z=%b c=%b want 1 4 fe 0 1", obsWe, obsAdd, obsData, obsZ, obsC);
        else checksPassed++;
    endtask

    task automatic test_back_to_back();
        logic firstReadyLow;
        applyStimulus(mkLdi(1, 8'h05), 1'b0); modelExec(mkLdi(1, 8'h05));
        applyStimulus(mkLdi(1, 8'h10), 1'b1); modelExec(mkLdi(1, 8'h10));
        firstReadyLow = obsReadyLow;
        applyStimulus(mkInstr(5, 5, 1, 1), 1'b0);
        modelExec(mkInstr(5, 5, 1, 1));
        checksTotal++;
        if ({obsWe, obsAdd, obsData, obsZ, obsC} !== {1'b1, 3'd5, 8'h10, 1'b0, 1'b0})
            $display("[TB] FAIL b2b_shl: got we=%b add=%0d data=%h z=%b c=%b want 1 5 10 0 0", obsWe, obsAdd, obsData, obsZ, obsC);
        else checksPassed++;
        checksTotal++;
        if ({firstReadyLow, obsReadyLow} !== 2'b11)
            $display("[TB] FAIL b2b_ready_low: got %b want 11", {firstReadyLow, obsReadyLow});
        else checksPassed++;
    endtask

    task automatic test_handshake();
        int idleActivity;
        logic [15:0] ins;
        idleActivity = 0;
        instr_valid  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (write_en || done || !instr_ready) idleActivity++;
        end
        ins = mkInstr(4, 6, 1, 2);
        applyStimulus(ins, 1'b0);
        modelExec(ins);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (write_en || done || !instr_ready) idleActivity++;
        end
        checksTotal++;
        if (idleActivity !== 0) $display("[TB] FAIL hs_idle_activity: got %0d want 0", idleActivity);
        else checksPassed++;
        checksTotal++;
        if ({obsWe, obsDone, obsAdd, obsData} !== {expWe, 1'b1, expAdd, expData})
            $display("[TB] FAIL hs_single: got we=%b done=%b add=%0d data=%h want %b 1 %0d %h",
                     obsWe, obsDone, obsAdd, obsData, expWe, expAdd, expData);
        else checksPassed++;
    endtask

    task automatic test_random();
        logic [15:0] ins;
        int op;
        bit hold;
        for (int i = 0; i < 24; i++) begin
            op = int'($urandom_range(0, 9));
            if (op == 8) ins = mkLdi(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
            else begin
                ins = mkInstr(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
                ins[2:0] = 3'($urandom);
            end
            hold = (i < 23) ? 1'($urandom_range(0, 1)) : 1'b0;
            applyStimulus(ins, hold);
            modelExec(ins);
            checksTotal++;
            if (timeoutHit !== 1'b0) $display("[TB] FAIL rnd_timeout[%0d]: got timeout want accept", i);
            else checksPassed++;
            checksTotal++;
            if ({obsWe, obsDone, obsEarly, obsReadyLow, obsReady4} !== {expWe, 1'b1, 1'b0, 1'b1, 1'b1})
                $display("[TB] FAIL rnd_strobes[%0d] ins=%h: got we/done/early/rdylow/rdy4=%b want %b", i, ins,
                         {obsWe, obsDone, obsEarly, obsReadyLow, obsReady4}, {expWe, 1'b1, 1'b0, 1'b1, 1'b1});
            else checksPassed++;
            if (expWe) begin
                checksTotal++;
                if ({obsAdd, obsData} !== {expAdd, expData})
                    $display("[TB] FAIL rnd_write[%0d] ins=%h: got add=%0d data=%h want %0d %h", i, ins, obsAdd, obsData, expAdd, expData);
                else checksPassed++;
            end
            checksTotal++;
            if ({obsZ, obsC, obsErr} !== {mZ, mC, mErr})
                $display("[TB] FAIL rnd_flags[%0d] ins=%h: got z/c/err=%b want %b", i, ins, {obsZ, obsC, obsErr}, {mZ, mC, mErr});
            else checksPassed++;
        end
        for (int r = 0; r < 8; r++) begin
            checksTotal++;
            if (rf[r] !== mRf[r]) $display("[TB] FAIL rnd_rf[%0d]: got %h want %h", r, rf[r], mRf[r]);
            else checksPassed++;
        end
    endtask

    task automatic test_illegal();
        logic keepZ, keepC;
        keepZ = mZ;
        keepC = mC;
        applyStimulus(16'hC000, 1'b0);
        modelExec(16'hC000);
        checksTotal++;
        if ({obsWe, obsDone, obsErr, obsZ, obsC} !== {1'b0, 1'b1, 1'b1, keepZ, keepC})
            $display("[TB] FAIL illegal_op: got we=%b done=%b err=%b z=%b c=%b want 0 1 1 %b %b",
                     obsWe, obsDone, obsErr, obsZ, obsC, keepZ, keepC);
        else checksPassed++;
        applyStimulus(mkInstr(0, 7, 1, 2), 1'b0);
        modelExec(mkInstr(0, 7, 1, 2));
        checksTotal++;
        if ({obsWe, obsErr, obsData} !== {1'b1, 1'b1, expData})
            $display("[TB] FAIL illegal_sticky: got we=%b err=%b data=%h want 1 1 %h", obsWe, obsErr, obsData, expData);
        else checksPassed++;
    endtask

    task automatic test_reset_mid_write();
        int waitCnt;
        applyStimulus(mkLdi(6, 8'h5A), 1'b0); modelExec(mkLdi(6, 8'h5A));
        applyStimulus(mkLdi(1, 8'h11), 1'b0); modelExec(mkLdi(1, 8'h11));
        applyStimulus(mkLdi(2, 8'h22), 1'b0); modelExec(mkLdi(2, 8'h22));
        instr_valid = 1'b1;
        instr       = mkInstr(0, 6, 1, 2);
        waitCnt     = 0;
        while (!instr_ready && waitCnt < 20) begin @(negedge clk); waitCnt++; end
        checksTotal++;
        if (instr_ready !== 1'b1) $display("[TB] FAIL midrst_accept: got ready=%b want 1", instr_ready);
        else checksPassed++;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2;
        checksTotal++;
        if (write_en !== 1'b1) $display("[TB] FAIL midrst_we_before: got %b want 1", write_en);
        else checksPassed++;
        rst = 1'b1;
        #1;
        checksTotal++;
        if ({write_en, done, err, flag_z, flag_c, instr_ready} !== 6'b0)
            $display("[TB] FAIL midrst_outputs: got we/done/err/z/c/rdy=%b want 000000",
                     {write_en, done, err, flag_z, flag_c, instr_ready});
        else checksPassed++;
        checksTotal++;
        if ({read_add1, read_add2, write_add, write_data} !== 17'h0)
            $display("[TB] FAIL midrst_addr_data: got %h want 0", {read_add1, read_add2, write_add, write_data});
        else checksPassed++;
        modelReset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checksTotal++;
        if (rf[6] !== 8'h5A) $display("[TB] FAIL midrst_r6: got %h want 5a", rf[6]);
        else checksPassed++;
        checksTotal++;
        if (instr_ready !== 1'b1) $display("[TB] FAIL midrst_idle: got ready=%b want 1", instr_ready);
        else checksPassed++;
    endtask

    initial begin
        test_reset();
        test_ldi_add();
        test_sub();
        test_back_to_back();
        test_handshake();
        test_random();
        test_illegal();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
